jump_x_unit: RTL and testbench

- Parametrised execute-stage unit for JAL/JALR in the out-of-order Blimp core.
- Computes the link value (pc+4) and the jump target.
- Sends a writeback message toward W and a redirect to fetch.
- Elastic pipeline of configurable depth with squash-by-age support; replaces the fixed single-cycle jump path.

---
 rtl/jump_x_unit.sv | 162 ++++++++++++++++
 tb/tb_jump_x_unit.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jump_x_unit.sv
// JAL/JALR execute unit: link/target generation, elastic pipe,
// independent writeback and fetch-redirect handshakes, squash by age.
module jump_x_unit #(
   parameter int p_seq_num_bits  = 5,
   parameter int p_num_phys_regs = 36,
   parameter int p_pipe_stages   = 1,
   parameter bit p_redirect_jal  = 1'b0,
   parameter int p_preg_bits     = $clog2(p_num_phys_regs)
) (
   input  logic                      clk,
   input  logic                      rst,

   input  logic                      d_val,
   output logic                      d_rdy,
   input  logic [31:0]               d_pc,
   input  logic [31:0]               d_imm,
   input  logic [31:0]               d_op1,
   input  logic                      d_is_jalr,
   input  logic [4:0]                d_waddr,
   input  logic [p_preg_bits-1:0]    d_preg,
   input  logic                      d_wen,
   input  logic [p_seq_num_bits-1:0] d_seq_num,

   output logic                      w_val,
   input  logic                      w_rdy,
   output logic [31:0]               w_wdata,
   output logic [4:0]                w_waddr,
   output logic [p_preg_bits-1:0]    w_preg,
   output logic                      w_wen,
   output logic [p_seq_num_bits-1:0] w_seq_num,

   output logic                      redir_val,
   input  logic                      redir_rdy,
   output logic [31:0]               redir_target,
   output logic [p_seq_num_bits-1:0] redir_seq_num,

   input  logic                      squash_val,
   input  logic [p_seq_num_bits-1:0] squash_seq_num
);

   localparam int c_last = p_pipe_stages - 1;

   typedef struct packed {
      logic [31:0]               link;
      logic [31:0]               tgt;
      logic [4:0]                waddr;
      logic [p_preg_bits-1:0]    preg;
      logic                      wen;
      logic [p_seq_num_bits-1:0] seq;
      logic                      nredir;
   } ent_t;

   ent_t                     r_ent [p_pipe_stages];
   logic [p_pipe_stages-1:0] r_vld;
   logic                     r_wdone;
   logic                     r_rdone;

   ent_t                     w_in;
   ent_t                     w_nxt [p_pipe_stages];
   logic [p_pipe_stages-1:0] w_nvld;
   logic [p_pipe_stages-1:0] w_free;
   logic                     w_wfire;
   logic                     w_rfire;
   logic                     w_retire;

   // Younger iff the modular distance lies in the lower half-window.
   function automatic logic f_younger(
      input logic [p_seq_num_bits-1:0] i_x,
      input logic [p_seq_num_bits-1:0] i_s
   );
      logic [p_seq_num_bits-1:0] w_diff;
      w_diff = i_x - i_s;
      return (w_diff != '0) && !w_diff[p_seq_num_bits-1];
   endfunction

   always_comb begin
      w_in        = '0;
      w_in.link   = d_pc + 32'd4;
      w_in.tgt    = d_is_jalr ? ((d_op1 + d_imm) & ~32'h1)
                              : (d_pc + d_imm);
      w_in.waddr  = d_waddr;
      w_in.preg   = d_preg;
      w_in.wen    = d_wen;
      w_in.seq    = d_seq_num;
      w_in.nredir = d_is_jalr | p_redirect_jal;
   end

   assign w_val         = r_vld[c_last] & ~r_wdone;
   assign redir_val     = r_vld[c_last] & ~r_rdone;
   assign w_wdata       = r_ent[c_last].link;
   assign w_waddr       = r_ent[c_last].waddr;
   assign w_preg        = r_ent[c_last].preg;
   assign w_wen         = r_ent[c_last].wen;
   assign w_seq_num     = r_ent[c_last].seq;
   assign redir_target  = r_ent[c_last].tgt;
   assign redir_seq_num = r_ent[c_last].seq;

   assign w_wfire  = w_val & w_rdy;
   assign w_rfire  = redir_val & redir_rdy;
   assign w_retire = r_vld[c_last]
                   & (r_wdone | w_wfire)
                   & (r_rdone | w_rfire);

   // A stage is free when empty or when its occupant moves on this cycle.
   always_comb begin
      w_free         = '0;
      w_free[c_last] = ~r_vld[c_last] | w_retire;
      for (int i = c_last - 1; i >= 0; i--) begin
         w_free[i] = ~r_vld[i] | w_free[i+1];
      end
   end

   assign d_rdy = w_free[0];

   always_comb begin
      w_nvld = '0;
      for (int i = 0; i < p_pipe_stages; i++) begin
         w_nxt[i] = w_in;
      end
      w_nvld[0] = d_val;
      for (int i = 1; i < p_pipe_stages; i++) begin
         w_nvld[i] = r_vld[i-1];
         w_nxt[i]  = r_ent[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld   <= '0;
         r_wdone <= 1'b0;
         r_rdone <= 1'b0;
      end else begin
         for (int i = 0; i < p_pipe_stages; i++) begin
            if (w_free[i]) begin
               r_vld[i] <= w_nvld[i]
                         & ~(squash_val &
                             f_younger(w_nxt[i].seq, squash_seq_num));
            end else begin
               r_vld[i] <= r_vld[i]
                         & ~(squash_val &
                             f_younger(r_ent[i].seq, squash_seq_num));
            end
         end
         if (w_free[c_last]) begin
            r_wdone <= 1'b0;
            r_rdone <= ~w_nxt[c_last].nredir;
         end else begin
            r_wdone <= r_wdone | w_wfire;
            r_rdone <= r_rdone | w_rfire;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < p_pipe_stages; i++) begin
         if (w_free[i]) begin
            r_ent[i] <= w_nxt[i];
         end
      end
   end

endmodule

// File: tb/tb_jump_x_unit.sv
// Bench for jump_x_unit: directed scenarios plus random traffic
// checked against an in-order queue model of outstanding ops.
module tb_jump_x_unit;

   localparam int SB  = 5;
   localparam int NP  = 36;
   localparam int PB  = 6;
   localparam int STG = 3;
   localparam int M   = 1 << SB;

   logic          clk = 1'b0;
   logic          rst;
   logic          d_val;
   logic          d_rdy;
   logic [31:0]   d_pc;
   logic [31:0]   d_imm;
   logic [31:0]   d_op1;
   logic          d_is_jalr;
   logic [4:0]    d_waddr;
   logic [PB-1:0] d_preg;
   logic          d_wen;
   logic [SB-1:0] d_seq_num;
   logic          w_val;
   logic          w_rdy;
   logic [31:0]   w_wdata;
   logic [4:0]    w_waddr;
   logic [PB-1:0] w_preg;
   logic          w_wen;
   logic [SB-1:0] w_seq_num;
   logic          redir_val;
   logic          redir_rdy;
   logic [31:0]   redir_target;
   logic [SB-1:0] redir_seq_num;
   logic          squash_val;
   logic [SB-1:0] squash_seq_num;

   jump_x_unit #(
      .p_seq_num_bits (SB),
      .p_num_phys_regs(NP),
      .p_pipe_stages  (STG),
      .p_redirect_jal (1'b0)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .d_val         (d_val),
      .d_rdy         (d_rdy),
      .d_pc          (d_pc),
      .d_imm         (d_imm),
      .d_op1         (d_op1),
      .d_is_jalr     (d_is_jalr),
      .d_waddr       (d_waddr),
      .d_preg        (d_preg),
      .d_wen         (d_wen),
      .d_seq_num     (d_seq_num),
      .w_val         (w_val),
      .w_rdy         (w_rdy),
      .w_wdata       (w_wdata),
      .w_waddr       (w_waddr),
      .w_preg        (w_preg),
      .w_wen         (w_wen),
      .w_seq_num     (w_seq_num),
      .redir_val     (redir_val),
      .redir_rdy     (redir_rdy),
      .redir_target  (redir_target),
      .redir_seq_num (redir_seq_num),
      .squash_val    (squash_val),
      .squash_seq_num(squash_seq_num)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int nseq    = 0;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic bit younger(input int x, input int s);
      int d;
      d = (((x - s) % M) + M) % M;
      return (d >= 1) && (d <= M/2 - 1);
   endfunction

   typedef struct {
      logic [31:0] link;
      logic [31:0] tgt;
      int          waddr;
      int          preg;
      bit          wen;
      int          seq;
      bit          wd;
      bit          rd;
      bit          ws;
      bit          rs;
   } op_t;

   op_t q[$];

   int          d_cyc[$];
   int          w_cyc[$];
   int          w_sq[$];
   logic [31:0] w_dat[$];
   int          r_cyc[$];
   logic [31:0] r_tgt[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (d_val && d_rdy) d_cyc.push_back(cyc);
      if (w_val && w_rdy &&
          !(squash_val && younger(int'(w_seq_num), int'(squash_seq_num)))) begin
         w_cyc.push_back(cyc);
         w_sq.push_back(int'(w_seq_num));
         w_dat.push_back(w_wdata);
      end
      if (redir_val && redir_rdy &&
          !(squash_val && younger(int'(redir_seq_num), int'(squash_seq_num)))) begin
         r_cyc.push_back(cyc);
         r_tgt.push_back(redir_target);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      d_cyc.delete(); w_cyc.delete(); w_sq.delete();
      w_dat.delete(); r_cyc.delete(); r_tgt.delete();
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] op1, input bit jalr,
                        input int seq);
      d_val     = 1'b1;
      d_pc      = pc;
      d_imm     = imm;
      d_op1     = op1;
      d_is_jalr = jalr;
      d_waddr   = 5'(seq + 1);
      d_preg    = PB'(seq % NP);
      d_wen     = 1'b1;
      d_seq_num = SB'(seq);
      step();
   endtask

   task automatic rcycle(input bit drain);
      bit whs, rhs, acc, ret;
      op_t h, n;
      step();
      w_rdy          = drain ? 1'b1 : ($urandom % 4 != 0);
      redir_rdy      = drain ? 1'b1 : ($urandom % 4 != 0);
      squash_val     = drain ? 1'b0 : ($urandom % 12 == 0);
      squash_seq_num = SB'(nseq - int'($urandom_range(0, 4)));
      d_val          = drain ? 1'b0 : ($urandom % 3 != 0);
      d_pc           = $urandom;
      d_imm          = $urandom;
      d_op1          = $urandom;
      d_is_jalr      = $urandom % 2;
      d_waddr        = 5'($urandom);
      d_preg         = PB'($urandom_range(0, NP - 1));
      d_wen          = $urandom % 2;
      d_seq_num      = SB'(nseq);
      @(negedge clk);
      whs = w_val && w_rdy;
      rhs = redir_val && redir_rdy;
      acc = d_val && d_rdy;
      if (q.size() == 0) begin
         check("idle_wval", w_val, 0);
         check("idle_rval", redir_val, 0);
         check("idle_drdy", d_rdy, 1);
      end else begin
         h = q[0];
         if (w_val) begin
            check("w_seq", w_seq_num, h.seq);
            check("w_data", w_wdata, h.link);
            check("w_waddr", w_waddr, h.waddr);
            check("w_preg", w_preg, h.preg);
            check("w_wen", w_wen, h.wen);
            check("w_once", h.wd, 0);
         end else if (h.ws && !h.wd) begin
            check("w_stable", w_val, 1);
         end
         if (redir_val) begin
            check("r_needed", h.rd, 0);
            check("r_tgt", redir_target, h.tgt);
            check("r_seq", redir_seq_num, h.seq);
         end else if (h.rs && !h.rd) begin
            check("r_stable", redir_val, 1);
         end
         if (q.size() == STG) begin
            ret = (h.wd || whs) && (h.rd || rhs);
            check("full_drdy", d_rdy, ret);
         end
      end
      if (q.size() > 0) begin
         if (w_val) q[0].ws = 1;
         if (whs)   q[0].wd = 1;
         if (redir_val) q[0].rs = 1;
         if (rhs)   q[0].rd = 1;
         if (q[0].wd && q[0].rd) void'(q.pop_front());
      end
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (squash_val && younger(q[i].seq, int'(squash_seq_num)))
            q.delete(i);
      end
      if (acc) begin
         if (!(squash_val && younger(nseq, int'(squash_seq_num)))) begin
            n.link  = d_pc + 4;
            n.tgt   = d_is_jalr ? ((d_op1 + d_imm) & 32'hFFFF_FFFE)
                                : (d_pc + d_imm);
            n.waddr = int'(d_waddr);
            n.preg  = int'(d_preg);
            n.wen   = d_wen;
            n.seq   = nseq;
            n.wd    = 0;
            n.rd    = !d_is_jalr;
            n.ws    = 0;
            n.rs    = 0;
            q.push_back(n);
         end
         nseq = (nseq + 1) % M;
      end
   endtask

   initial begin
      int n;
      rst = 1; d_val = 0; d_pc = 0; d_imm = 0; d_op1 = 0;
      d_is_jalr = 0; d_waddr = 0; d_preg = 0; d_wen = 0;
      d_seq_num = 0; w_rdy = 1; redir_rdy = 1;
      squash_val = 0; squash_seq_num = 0;
      step(); step();
      rst = 0;
      @(negedge clk);
      check("rst_wval", w_val, 0);
      check("rst_rval", redir_val, 0);
      check("rst_drdy", d_rdy, 1);

      clear_logs();
      drive(32'h200, 32'h10, 32'h0, 0, 1);
      d_val = 0;
      repeat (6) step();
      check("jal_wn", w_sq.size(), 1);
      check("jal_rn", r_cyc.size(), 0);
      if (w_sq.size() == 1 && d_cyc.size() == 1) begin
         check("jal_link", w_dat[0], 32'h204);
         check("jal_lat", w_cyc[0] - d_cyc[0], STG);
      end

      clear_logs();
      drive(32'h300, 32'h4, 32'h1003, 1, 2);
      d_val = 0;
      repeat (6) step();
      check("jalr_wn", w_sq.size(), 1);
      check("jalr_rn", r_cyc.size(), 1);
      if (w_sq.size() == 1 && r_cyc.size() == 1 && d_cyc.size() == 1) begin
         check("jalr_link", w_dat[0], 32'h304);
         check("jalr_tgt", r_tgt[0], 32'h1006);
         check("jalr_wlat", w_cyc[0] - d_cyc[0], STG);
         check("jalr_rlat", r_cyc[0] - d_cyc[0], STG);
      end

      clear_logs();
      for (int k = 0; k < 4; k++)
         drive(32'h1000 + 16*k, 32'h8, 32'h2000 + 4*k, 1, (30 + k) % M);
      d_val = 0;
      repeat (8) step();
      check("b2b_wn", w_sq.size(), 4);
      check("b2b_rn", r_cyc.size(), 4);
      if (w_sq.size() == 4 && d_cyc.size() == 4) begin
         check("b2b_lat", w_cyc[0] - d_cyc[0], STG);
         for (int k = 0; k < 4; k++) begin
            check("b2b_seq", w_sq[k], (30 + k) % M);
            check("b2b_cyc", w_cyc[k] - w_cyc[0], k);
         end
      end

      clear_logs();
      redir_rdy = 0;
      drive(32'h500, 32'h20, 32'h3001, 1, 7);
      drive(32'h540, 32'h40, 32'h0, 0, 8);
      drive(32'h580, 32'h40, 32'h0, 0, 9);
      d_val = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rs_rval", redir_val, 1);
         check("rs_tgt", redir_target, 32'h3020);
         check("rs_wval", w_val, (k == 0));
         check("rs_drdy", d_rdy, 0);
         step();
      end
      redir_rdy = 1;
      repeat (6) step();
      check("rs_wn", w_sq.size(), 3);
      check("rs_rn", r_cyc.size(), 1);
      if (w_sq.size() == 3 && r_cyc.size() == 1) begin
         check("rs_seq0", w_sq[0], 7);
         check("rs_seq1", w_sq[1], 8);
         check("rs_seq2", w_sq[2], 9);
         check("rs_gap", r_cyc[0] - w_cyc[0], 3);
      end

      clear_logs();
      w_rdy = 0;
      drive(32'h600, 32'h0, 32'h0, 0, 3);
      drive(32'h610, 32'h0, 32'h0, 0, 4);
      drive(32'h620, 32'h0, 32'h0, 0, 5);
      d_pc = 32'h630; d_seq_num = 6; d_val = 1;
      squash_val = 1; squash_seq_num = 4; w_rdy = 1;
      @(negedge clk);
      check("sq_drdy", d_rdy, 1);
      step();
      squash_val = 0; d_val = 0;
      repeat (8) step();
      check("sq_dn", d_cyc.size(), 4);
      check("sq_wn", w_sq.size(), 2);
      if (w_sq.size() == 2) begin
         check("sq_seq0", w_sq[0], 3);
         check("sq_seq1", w_sq[1], 4);
      end

      w_rdy = 0; redir_rdy = 0;
      drive(32'h700, 32'h0, 32'h800, 1, 10);
      drive(32'h710, 32'h4, 32'h0, 0, 11);
      d_val = 0;
      n = 0;
      while (!redir_val && n < 10) begin
         step();
         n++;
      end
      check("mid_rval", redir_val, 1);
      rst = 1;
      step();
      rst = 0;
      @(negedge clk);
      check("mid_wval", w_val, 0);
      check("mid_rval0", redir_val, 0);
      check("mid_drdy", d_rdy, 1);
      w_rdy = 1; redir_rdy = 1;
      clear_logs();
      drive(32'h400, 32'h8, 32'h0, 0, 12);
      d_val = 0;
      repeat (6) step();
      check("post_wn", w_sq.size(), 1);
      check("post_rn", r_cyc.size(), 0);
      if (w_sq.size() == 1) begin
         check("post_data", w_dat[0], 32'h404);
         check("post_seq", w_sq[0], 12);
      end

      nseq = 20;
      q.delete();
      repeat (2000) rcycle(0);
      repeat (20) rcycle(1);
      check("drain_empty", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
